// File: rtl/ctr_dir_decoder.sv
// Purpose : checks an up/down counter stream, locks onto its direction and flags reversals, wraps and illegal steps.
// Latency : one cycle; every output is a register loaded on the edge that samples cnt_in.
// Backpres: none; cnt_vld only qualifies samples, and cycles with it low freeze all state.
//
// Ports:
//   clk, rstn            rising-edge clock, asynchronous active-low reset
//   cnt_in, cnt_vld      observed counter value and its sample qualifier
//   dir                  last decoded direction (1 = up, 0 = down)
//   locked               direction lock acquired
//   rev_pulse            one-cycle pulse on a direction reversal while locked
//   wrap_pulse           one-cycle pulse on a legal step across max<->0
//   err_pulse            one-cycle pulse on an illegal step
//   err_cnt              saturating illegal-step count
//
// Build option: define CTR_DEC_ERRCNT_EN to implement err_cnt; otherwise it reads 0.
module ctr_dir_decoder #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_vld,
    output logic             dir,
    output logic             locked,
    output logic             rev_pulse,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ACQ   = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);

    state_t           state, state_d;
    logic [WIDTH-1:0] prev, prev_d;
    logic [3:0]       run_cnt, run_d;
    logic             dir_d, locked_d;
    logic             rev_d, wrap_d, err_d;

    logic [WIDTH-1:0] delta;
    step_t            step;
    logic             step_up;
    logic             step_wrap;
    logic [3:0]       run_inc;

    // Step classification relative to the previous sample (modular difference).
    always_comb begin
        delta = cnt_in - prev;
        if (delta == CNT_ZERO) begin
            step = STEP_HOLD;
        end else if (delta == CNT_ONE) begin
            step = STEP_UP;
        end else if (delta == CNT_MAX) begin
            step = STEP_DOWN;
        end else begin
            step = STEP_ILL;
        end
        step_up   = (step == STEP_UP);
        step_wrap = ((step == STEP_UP) && (cnt_in == CNT_ZERO)) ||
                    ((step == STEP_DOWN) && (cnt_in == CNT_MAX));
        // An empty run (fresh acquisition) restarts at 1 whatever the direction.
        if ((run_cnt != 4'd0) && (step_up == dir)) begin
            run_inc = run_cnt + 4'd1;
        end else begin
            run_inc = 4'd1;
        end
    end

    always_comb begin
        state_d = state;
        prev_d  = prev;
        run_d   = run_cnt;
        dir_d   = dir;
        rev_d   = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (cnt_vld) begin
            prev_d = cnt_in;
            unique case (state)
                ST_EMPTY: begin
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if ((step == STEP_UP) || (step == STEP_DOWN)) begin
                        dir_d  = step_up;
                        wrap_d = step_wrap;
                        run_d  = run_inc;
                        if (run_inc >= LOCK_N) begin
                            state_d = ST_LOCK;
                        end
                    end else if (step == STEP_ILL) begin
                        run_d = 4'd0;
                        err_d = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if ((step == STEP_UP) || (step == STEP_DOWN)) begin
                        dir_d  = step_up;
                        wrap_d = step_wrap;
                        rev_d  = (step_up != dir);
                    end else if (step == STEP_ILL) begin
                        state_d = ST_ACQ;
                        run_d   = 4'd0;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_EMPTY;
            prev       <= '0;
            run_cnt    <= 4'd0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            rev_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_d;
            prev       <= prev_d;
            run_cnt    <= run_d;
            dir        <= dir_d;
            locked     <= locked_d;
            rev_pulse  <= rev_d;
            wrap_pulse <= wrap_d;
            err_pulse  <= err_d;
        end
    end

`ifdef CTR_DEC_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q;

    // Counts alongside err_pulse so both become visible in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ctr_dir_decoder.sv
module tb_ctr_dir_decoder;

    localparam int W = 3;
    localparam int L = 2;
    localparam int M = 1 << W;

    logic         clk;
    logic         rstn;
    logic [W-1:0] cnt_in;
    logic         cnt_vld;
    logic         dir, locked, rev_pulse, wrap_pulse, err_pulse;
    logic [7:0]   err_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit dir;
        bit locked;
        bit rev;
        bit wrap;
        bit err;
        int errc;
    } exp_t;

    exp_t sb[$];

    // Behavioural reference: 0 = empty, 1 = acquiring, 2 = locked.
    int m_state, m_prev, m_run, m_errc;
    bit m_dir;

    ctr_dir_decoder #(.WIDTH(W), .LOCK_CNT(L), .ERR_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cnt_in    (cnt_in),
        .cnt_vld   (cnt_vld),
        .dir       (dir),
        .locked    (locked),
        .rev_pulse (rev_pulse),
        .wrap_pulse(wrap_pulse),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_prev  = 0;
        m_run   = 0;
        m_errc  = 0;
        m_dir   = 1'b0;
    endtask

    task automatic model_push(input bit vld, input int v);
        exp_t e;
        int   d;
        bit   up;
        e.rev  = 1'b0;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        if (vld) begin
            if (m_state == 0) begin
                m_state = 1;
            end else begin
                d = (v - m_prev + M) % M;
                if (d == 1 || d == M - 1) begin
                    up     = (d == 1);
                    e.wrap = up ? (v == 0) : (v == M - 1);
                    if (m_state == 2) begin
                        e.rev = (up != m_dir);
                    end else begin
                        m_run = (m_run > 0 && up == m_dir) ? m_run + 1 : 1;
                        if (m_run == L) m_state = 2;
                    end
                    m_dir = up;
                end else if (d != 0) begin
                    e.err   = 1'b1;
                    m_run   = 0;
                    m_state = 1;
`ifdef CTR_DEC_ERRCNT_EN
                    if (m_errc < 255) m_errc++;
`endif
                end
            end
            m_prev = v;
        end
        e.dir    = m_dir;
        e.locked = (m_state == 2);
        e.errc   = m_errc;
        sb.push_back(e);
    endtask

    // Present one cycle of stimulus, then compare against the scoreboard head.
    task automatic drive(input bit vld, input int v);
        exp_t e;
        cnt_vld = vld;
        cnt_in  = W'(v);
        model_push(vld, v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("dir",    32'(dir),        32'(e.dir));
            chk("locked", 32'(locked),     32'(e.locked));
            chk("rev",    32'(rev_pulse),  32'(e.rev));
            chk("wrap",   32'(wrap_pulse), 32'(e.wrap));
            chk("err",    32'(err_pulse),  32'(e.err));
            chk("errcnt", 32'(err_cnt),    32'(e.errc));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dir"},    32'(dir),        32'd0);
        chk({tag, "_locked"}, 32'(locked),     32'd0);
        chk({tag, "_rev"},    32'(rev_pulse),  32'd0);
        chk({tag, "_wrap"},   32'(wrap_pulse), 32'd0);
        chk({tag, "_err"},    32'(err_pulse),  32'd0);
        chk({tag, "_errcnt"}, 32'(err_cnt),    32'd0);
    endtask

    initial begin
        int v;
        rstn    = 1'b0;
        cnt_vld = 1'b0;
        cnt_in  = '0;
        model_reset();
        #1;
        chk_all_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Acquire on an up stream 0,1,2,3.
        drive(1, 0);
        drive(1, 1);
        chk("acq_not_locked", 32'(locked), 32'd0);
        drive(1, 2);
        chk("lock_after_s2", 32'(locked), 32'd1);
        chk("lock_dir_up", 32'(dir), 32'd1);
        drive(1, 3);

        // Up through the wrap.
        drive(1, 4);
        drive(1, 5);
        drive(1, 6);
        drive(1, 7);
        chk("no_wrap_6_7", 32'(wrap_pulse), 32'd0);
        drive(1, 0);
        chk("wrap_7_0", 32'(wrap_pulse), 32'd1);
        chk("wrap_locked", 32'(locked), 32'd1);
        drive(1, 1);
        chk("wrap_single", 32'(wrap_pulse), 32'd0);

        // Reversal from 4: 3 then 2.
        drive(1, 2);
        drive(1, 3);
        drive(1, 4);
        drive(1, 3);
        chk("rev_4_3", 32'(rev_pulse), 32'd1);
        chk("rev_dir", 32'(dir), 32'd0);
        drive(1, 2);
        chk("rev_once", 32'(rev_pulse), 32'd0);
        chk("rev_still_locked", 32'(locked), 32'd1);

        // Illegal jump 2->5, then relock with 6,7.
        drive(1, 5);
        chk("ill_err", 32'(err_pulse), 32'd1);
        chk("ill_unlock", 32'(locked), 32'd0);
        drive(1, 6);
        drive(1, 7);
        chk("relock", 32'(locked), 32'd1);

        // Up to 0 (wrap), then back to 7: reversal and wrap together.
        drive(1, 0);
        drive(1, 7);
        chk("revwrap_rev", 32'(rev_pulse), 32'd1);
        chk("revwrap_wrap", 32'(wrap_pulse), 32'd1);
        drive(1, 7);

        // Gap with garbage on cnt_in; next sample measured against 7.
        for (int i = 0; i < 5; i++) begin
            drive(0, int'($urandom_range(0, M - 1)));
        end
        drive(1, 0);
        chk("gap_rev", 32'(rev_pulse), 32'd1);
        chk("gap_wrap", 32'(wrap_pulse), 32'd1);

        // Asynchronous reset while locked, away from any clock edge.
        chk("pre_rst_locked", 32'(locked), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("arst");
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(1, 5);
        chk("post_rst_first", 32'(dir), 32'd0);
        drive(1, 6);
        chk("post_rst_acq", 32'(locked), 32'd0);
        drive(1, 7);

        // Long run of illegal steps (+4 each) for counter saturation.
        v = 7;
        for (int i = 0; i < 260; i++) begin
            v = (v + 4) % M;
            drive(1, v);
        end
`ifdef CTR_DEC_ERRCNT_EN
        chk("errcnt_sat", 32'(err_cnt), 32'd255);
`else
        chk("errcnt_off", 32'(err_cnt), 32'd0);
`endif
        chk("sat_err_pulse", 32'(err_pulse), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctr_dir_decoder.md
# ctr_dir_decoder

Receive-side companion to the up/down counter. It samples a free-running WIDTH-bit up/down count value each enabled cycle, classifies every step as up, down, hold or illegal, locks onto the counting direction and reports direction, reversals, wrap-arounds and step errors. It sits downstream of the counter and checks its output stream, in the bench and in-system.

## Interface
- WIDTH, 3: count width, must be ≥ 2.
- LOCK_CNT, 2: consecutive same-direction legal steps required to enter LOCK, 1..15.
- ERR_W, 8: error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- cnt_in  in  WIDTH  observed counter value.
- cnt_vld  in  1  cnt_in is sampled when high; ignored otherwise.
- dir  out  1  last decoded direction: 1 = up, 0 = down.
- locked  out  1  FSM in LOCK.
- rev_pulse  out  1  one-cycle pulse on a direction reversal while LOCK.
- wrap_pulse  out  1  one-cycle pulse on a legal step across the wrap: max→0 up, or 0→max down.
- err_pulse  out  1  one-cycle pulse on an illegal step.
- err_cnt  out  ERR_W  saturating illegal-step count.

## Operation
- Step on each sample after the first: d = (cnt_in − prev) mod 2^WIDTH. d = 1 means UP. d = 2^WIDTH−1 means DOWN. d = 0 means HOLD. Any other d means ILLEGAL. prev is updated on every sample.
- FSM states and transitions:
  - EMPTY, entered on reset: the first sample loads prev → ACQ. No classification is done.
  - ACQ: UP or DOWN in the same direction as the run increments run_cnt. An opposite direction restarts run_cnt at 1 and sets dir. When run_cnt reaches LOCK_CNT → LOCK. HOLD changes nothing. ILLEGAL clears run_cnt and stays in ACQ.
  - LOCK: UP or DOWN matching dir stays in LOCK. The opposite direction flips dir, pulses rev_pulse and stays in LOCK. HOLD stays in LOCK. ILLEGAL → ACQ with run_cnt = 0.
- dir updates on every legal UP or DOWN step in any state.
- In ACQ, a direction change does not pulse rev_pulse.
- wrap_pulse is asserted for legal wrap steps in ACQ and LOCK.
- err_pulse is asserted for ILLEGAL steps in ACQ and LOCK. err_cnt increments on each err_pulse and saturates at all-ones.
- A cycle with cnt_vld low changes neither state nor prev. All pulses are low in that cycle.
- A reversal that also wraps (for example 0 after an UP run, then max) asserts rev_pulse and wrap_pulse in the same cycle.

## Timing
- All outputs are registered. A sample taken at edge N is reflected at edge N+1, giving one cycle of latency.
- rev_pulse, wrap_pulse and err_pulse are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- With LOCK_CNT = L and a continuous legal stream starting from EMPTY, locked rises one cycle after the (L+1)-th sample.
- Reset values of every output and internal register: dir = 0, locked = 0, all pulses = 0, err_cnt = 0, state = EMPTY, prev = 0, run_cnt = 0.
- Reset asserted mid-run clears everything immediately, with no dependency on clk.
- After reset deasserts, the next sample is treated as a first sample: no step is classified.

## Configuration
- CTR_DEC_ERRCNT_EN:
  - Defined: err_cnt is implemented as specified.
  - Undefined: err_cnt is tied to 0 and the counter register is removed. err_pulse still operates.

## Test plan
- WIDTH=3, LOCK_CNT=2, cnt_vld=1, stream 0,1,2,3 → locked=1 one cycle after sample 2 is taken, dir=1, no pulses.
- Locked up, stream 6,7,0,1 → wrap_pulse on the 7→0 step only, dir stays 1, locked stays 1.
- Locked up at 4, stream 3,2 → rev_pulse once at the 4→3 step, dir=0, locked stays 1.
- Locked, jump 2→5 → err_pulse=1, locked=0, err_cnt=1. Then 6,7 → locked=1 again. 255 further illegal steps → err_cnt holds at 255 (macro defined) or stays 0 (macro undefined).
- cnt_vld low for 5 cycles with cnt_in changing arbitrarily → no state change and no pulses. The next valid sample is classified against the pre-gap prev.
- rstn low mid-stream while locked → all outputs 0 asynchronously. After release, first sample 5 → no pulse, state ACQ.
